// File: rtl/disp_sched_if.sv
// Bundles the scheduler's control inputs, time sources and display outputs.
interface disp_sched_if;
  logic        mode_btn;
  logic        peek_req;
  logic [1:0]  peek_page;
  logic        alarm_ring;
  logic [20:0] src0_data;
  logic [20:0] src1_data;
  logic [20:0] src2_data;
  logic [20:0] data;
  logic [1:0]  page;
  logic        peeking;

  modport master (
    output mode_btn, peek_req, peek_page, alarm_ring, src0_data, src1_data, src2_data,
    input  data, page, peeking
  );

  modport slave (
    input  mode_btn, peek_req, peek_page, alarm_ring, src0_data, src1_data, src2_data,
    output data, page, peeking
  );
endinterface

// File: rtl/disp_sched.sv
// Chooses which time source drives the 7-segment data bus: round-robin base page,
// a timed peek overlay, and a forced alarm page while the alarm rings.
module disp_sched #(
  parameter int unsigned HOLD_CYCLES = 150_000_000
) (
  input logic         clk,
  input logic         rst,
  disp_sched_if.slave bus
);

  localparam int unsigned HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {NORMAL, PEEK, FORCE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  base_page_q, base_page_d;
  logic [1:0]  peek_pg_q, peek_pg_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [20:0] data_q, data_d;
  logic [1:0]  page_q, page_d;
  logic        peeking_q, peeking_d;

  logic        peek_ok;
  logic [1:0]  base_next;
  logic [20:0] sel;

  function automatic logic [6:0] clamp7(input logic [6:0] f);
    return (f > 7'd99) ? 7'd99 : f;
  endfunction

  assign peek_ok   = bus.peek_req && (bus.peek_page != 2'd3);
  assign base_next = (base_page_q == 2'd2) ? 2'd0 : base_page_q + 2'd1;

  always_comb begin
    state_d     = state_q;
    base_page_d = base_page_q;
    peek_pg_d   = peek_pg_q;
    hold_cnt_d  = hold_cnt_q;
    unique case (state_q)
      NORMAL: begin
        if (bus.alarm_ring) begin
          state_d = FORCE;
        end else if (peek_ok) begin
          state_d    = PEEK;
          peek_pg_d  = bus.peek_page;
          hold_cnt_d = HOLD_LOAD;
        end else if (bus.mode_btn) begin
          base_page_d = base_next;
        end
      end
      PEEK: begin
        if (bus.alarm_ring) begin
          state_d = FORCE;
        end else if (peek_ok) begin
          peek_pg_d  = bus.peek_page;
          hold_cnt_d = HOLD_LOAD;
        end else if (bus.mode_btn) begin
          state_d = NORMAL;
        end else if (hold_cnt_q == '0) begin
          state_d = NORMAL;
        end else begin
          hold_cnt_d = hold_cnt_q - HW'(1);
        end
      end
      FORCE: begin
        if (!bus.alarm_ring) state_d = NORMAL;
      end
      default: state_d = NORMAL;
    endcase
  end

  // Output registers are fed from the next-state selection so page and data
  // always describe the same source in the same cycle.
  always_comb begin
    page_d    = base_page_d;
    peeking_d = 1'b0;
    unique case (state_d)
      PEEK: begin
        page_d    = peek_pg_d;
        peeking_d = 1'b1;
      end
      FORCE:   page_d = 2'd1;
      default: page_d = base_page_d;
    endcase
    unique case (page_d)
      2'd0:    sel = bus.src0_data;
      2'd1:    sel = bus.src1_data;
      2'd2:    sel = bus.src2_data;
      default: sel = '0;
    endcase
    data_d = {clamp7(sel[20:14]), clamp7(sel[13:7]), clamp7(sel[6:0])};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= NORMAL;
      base_page_q <= '0;
      peek_pg_q   <= '0;
      hold_cnt_q  <= '0;
      data_q      <= '0;
      page_q      <= '0;
      peeking_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_page_q <= base_page_d;
      peek_pg_q   <= peek_pg_d;
      hold_cnt_q  <= hold_cnt_d;
      data_q      <= data_d;
      page_q      <= page_d;
      peeking_q   <= peeking_d;
    end
  end

  assign bus.data    = data_q;
  assign bus.page    = page_q;
  assign bus.peeking = peeking_q;

endmodule

// File: tb/tb_disp_sched.sv
// Scoreboard bench for disp_sched with HOLD_CYCLES = 4 and fixed source words.
module tb_disp_sched;

  localparam logic [20:0] W0 = {7'd12, 7'd34, 7'd56};
  localparam logic [20:0] W1 = {7'd7,  7'd0,  7'd0};
  localparam logic [20:0] W2 = {7'd0,  7'd1,  7'd23};

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [23:0] sb_q[$];
  logic [23:0] act_q[$];
  string       nm_q[$];

  disp_sched_if bus_if ();

  disp_sched #(.HOLD_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [20:0] wexp(input logic [1:0] p);
    case (p)
      2'd0:    return W0;
      2'd1:    return W1;
      2'd2:    return W2;
      default: return '0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of stimulus and records the expected/observed result pair.
  task automatic apply(input logic m, input logic pk, input logic [1:0] pp, input logic al,
                       input logic epk, input logic [1:0] epg, input string nm);
    bus_if.mode_btn   = m;
    bus_if.peek_req   = pk;
    bus_if.peek_page  = pp;
    bus_if.alarm_ring = al;
    sb_q.push_back({epk, epg, wexp(epg)});
    nm_q.push_back(nm);
    tick();
    act_q.push_back({bus_if.peeking, bus_if.page, bus_if.data});
    bus_if.mode_btn = 1'b0;
    bus_if.peek_req = 1'b0;
  endtask

  task automatic test_reset();
    logic [23:0] e, a;
    string n;
    rst = 1'b0;
    bus_if.mode_btn = 1'b0; bus_if.peek_req = 1'b0; bus_if.peek_page = 2'd0;
    bus_if.alarm_ring = 1'b0;
    bus_if.src0_data = W0; bus_if.src1_data = W1; bus_if.src2_data = W2;
    #2;
    sb_q.push_back('0); nm_q.push_back("reset_state");
    act_q.push_back({bus_if.peeking, bus_if.page, bus_if.data});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, "reset_first_idle");
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); a = act_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got pk=%b pg=%0d data=%h, expected pk=%b pg=%0d data=%h",
                 n, a[23], a[22:21], a[20:0], e[23], e[22:21], e[20:0]);
      end
    end
  endtask

  task automatic test_mode();
    logic [23:0] e, a;
    string n;
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, "mode_to1");
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, "mode_hold1");
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, "mode_to2");
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, "mode_hold2");
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, "mode_wrap0");
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, "mode_hold0");
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); a = act_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got pk=%b pg=%0d data=%h, expected pk=%b pg=%0d data=%h",
                 n, a[23], a[22:21], a[20:0], e[23], e[22:21], e[20:0]);
      end
    end
  endtask

  task automatic test_peek();
    logic [23:0] e, a;
    string n;
    apply(1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 2'd2, "peek_start");
    for (int i = 0; i < 3; i++)
      apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, "peek_active");
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, "peek_expired");
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, "peek_after");
    // invalid page inside PEEK must not reload the hold counter
    apply(1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 2'd2, "inv_peek_start");
    apply(1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 2'd2, "inv_in_peek");
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, "inv_in_peek_cnt");
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, "inv_in_peek_last");
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, "inv_in_peek_exp");
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); a = act_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got pk=%b pg=%0d data=%h, expected pk=%b pg=%0d data=%h",
                 n, a[23], a[22:21], a[20:0], e[23], e[22:21], e[20:0]);
      end
    end
  endtask

  task automatic test_retrigger();
    logic [23:0] e, a;
    string n;
    apply(1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 2'd2, "rt_start");
    for (int i = 0; i < 3; i++)
      apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, "rt_count");
    apply(1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 2'd1, "rt_retrig_last");
    for (int i = 0; i < 3; i++)
      apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd1, "rt_window");
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, "rt_expire");
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, "mm_base1");
    apply(1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 2'd2, "mm_peek");
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 2'd2, "mm_peek_hold");
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, "mm_exit_base");
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, "mm_stay");
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, "mm_to2");
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, "mm_to0");
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); a = act_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got pk=%b pg=%0d data=%h, expected pk=%b pg=%0d data=%h",
                 n, a[23], a[22:21], a[20:0], e[23], e[22:21], e[20:0]);
      end
    end
  endtask

  task automatic test_alarm();
    logic [23:0] e, a;
    string n;
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, "alm_m1");
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, "alm_m2");
    apply(1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 2'd0, "alm_peek");
    apply(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1, "alm_force");
    apply(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1, "alm_mode_ign");
    apply(1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 2'd1, "alm_peek_ign");
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, "alm_release");
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, "alm_no_resume");
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, "alm_base_wrap");
    apply(1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1, "alm_normal_mode");
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, "alm_base_kept");
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); a = act_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got pk=%b pg=%0d data=%h, expected pk=%b pg=%0d data=%h",
                 n, a[23], a[22:21], a[20:0], e[23], e[22:21], e[20:0]);
      end
    end
  endtask

  task automatic test_clamp_invalid();
    logic [23:0] e, a;
    string n;
    bus_if.src0_data = {7'd127, 7'd100, 7'd99};
    sb_q.push_back({1'b0, 2'd0, {7'd99, 7'd99, 7'd99}}); nm_q.push_back("clamp_all");
    tick();
    act_q.push_back({bus_if.peeking, bus_if.page, bus_if.data});
    bus_if.src0_data = {7'd100, 7'd50, 7'd127};
    sb_q.push_back({1'b0, 2'd0, {7'd99, 7'd50, 7'd99}}); nm_q.push_back("clamp_mixed");
    tick();
    act_q.push_back({bus_if.peeking, bus_if.page, bus_if.data});
    bus_if.src0_data = W0;
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, "clamp_restore");
    apply(1'b1, 1'b1, 2'd3, 1'b0, 1'b0, 2'd1, "inv_with_mode");
    apply(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 2'd1, "inv_alone");
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd2, "inv_to2");
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, "inv_to0");
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); a = act_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got pk=%b pg=%0d data=%h, expected pk=%b pg=%0d data=%h",
                 n, a[23], a[22:21], a[20:0], e[23], e[22:21], e[20:0]);
      end
    end
  endtask

  task automatic test_reset_mid_peek();
    logic [23:0] e, a;
    string n;
    apply(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, "rstp_base1");
    apply(1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 2'd2, "rstp_peek");
    #2;
    rst = 1'b0;
    #1;
    sb_q.push_back('0); nm_q.push_back("rstp_async_zero");
    act_q.push_back({bus_if.peeking, bus_if.page, bus_if.data});
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, "rstp_after_release");
    apply(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 2'd0, "rstp_no_peek");
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front(); a = act_q.pop_front(); n = nm_q.pop_front();
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: got pk=%b pg=%0d data=%h, expected pk=%b pg=%0d data=%h",
                 n, a[23], a[22:21], a[20:0], e[23], e[22:21], e[20:0]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_mode();
    test_peek();
    test_retrigger();
    test_alarm();
    test_clamp_invalid();
    test_reset_mid_peek();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/disp_sched.md
# disp_sched

Display-source scheduler that sits directly in front of the 8-digit seven-segment driver and decides which of three 21-bit time sources (clock time, alarm setting, stopwatch) is shown. It provides round-robin page selection from a mode button, a timed "peek" overlay that reverts automatically, and a forced alarm page while the alarm rings. Its registered output is the driver's `data` bus: three 7-bit fields `{hi[20:14], mid[13:7], lo[6:0]}`, each clamped to 0–99.

## Interface
- `HOLD_CYCLES`, default 150_000_000: peek duration in clk cycles (3 s at 50 MHz); must be ≥1.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-low reset.
- `mode_btn`  in  1  single-cycle pulse, already debounced; advances the base page.
- `peek_req`  in  1  single-cycle pulse; starts or restarts a peek of `peek_page`.
- `peek_page`  in  2  page to peek; only values 0–2 are valid.
- `alarm_ring`  in  1  level; while high the alarm page is forced.
- `src0_data`  in  21  page 0: clock time.
- `src1_data`  in  21  page 1: alarm setting.
- `src2_data`  in  21  page 2: stopwatch.
- `data`  out  21  registered display word to the segment driver.
- `page`  out  2  page currently being shown (registered).
- `peeking`  out  1  high while in PEEK.

## Operation
- State: `state` ∈ {NORMAL, PEEK, FORCE}; `base_page` (0–2); `peek_pg` (0–2); `hold_cnt`, wide enough for HOLD_CYCLES−1.
- Displayed page: NORMAL → `base_page`; PEEK → `peek_pg`; FORCE → 1.
- NORMAL:
  - `alarm_ring` high → FORCE. `mode_btn` and `peek_req` in the same cycle are discarded.
  - Else a valid `peek_req` → PEEK, with `peek_pg <= peek_page` and `hold_cnt <= HOLD_CYCLES-1`. `mode_btn` in the same cycle is discarded.
  - Else `mode_btn` → `base_page` advances 0→1→2→0.
- PEEK:
  - `alarm_ring` high → FORCE; the peek is abandoned.
  - Else a valid `peek_req` reloads `peek_pg` and `hold_cnt`; the state remains PEEK.
  - Else `mode_btn` → NORMAL; `base_page` is unchanged.
  - Else, if `hold_cnt == 0` → NORMAL; otherwise `hold_cnt` decrements.
- FORCE:
  - `mode_btn` and `peek_req` are ignored.
  - `alarm_ring` low → NORMAL with `base_page` as it was before the alarm.
- Invalid `peek_page == 3`: the `peek_req` is dropped in every state. It takes no priority, so `mode_btn` in the same cycle is processed normally.
- Clamp: each 7-bit field of the selected source becomes `(f > 99) ? 99 : f`, independently per field.

## Timing
- Reset (async assert, `rst` low) sets:
  - `state` = NORMAL, `base_page` = 0, `peek_pg` = 0, `hold_cnt` = 0;
  - `data` = 0, `page` = 0, `peeking` = 0.
- Reset mid-PEEK or mid-FORCE returns immediately to these values.
- State and page registers update on the clk edge that samples an event.
- `page` and `peeking` reflect the new state one cycle after the event.
- `data` is computed from the next-cycle page selection and the current source values. It is valid in the same cycle as `page`, so `data` and `page` are always coherent.
- Source changes appear on `data` one cycle later.
- Peek length: `peeking` is high for exactly HOLD_CYCLES cycles after an unretriggered `peek_req`.
  - With HOLD_CYCLES = 1, `peeking` is high for one cycle.
- A `peek_req` retrigger in the last PEEK cycle (`hold_cnt == 0`) wins over expiry. A full HOLD_CYCLES window restarts.
- `alarm_ring` is sampled every cycle; there is no minimum FORCE duration.

## Test plan
All scenarios use HOLD_CYCLES = 4, `src0` = {12,34,56}, `src1` = {7,0,0}, `src2` = {0,1,23}.
- Reset, then 3 `mode_btn` pulses spaced 2 cycles apart → `page` goes 0→1→2→0. `data` follows, e.g. {0,1,23} one cycle after the 2nd pulse.
- `peek_req` with `peek_page` = 2 from base 0 → `page` = 2 and `peeking` = 1 for exactly 4 cycles, then `page` = 0 and `data` = {12,34,56}.
- Peek retriggered at `hold_cnt` = 0 with `peek_page` = 1 → `page` = 1 for 4 further cycles. Separately, `mode_btn` mid-peek → NORMAL with the base unchanged.
- `alarm_ring` raised in PEEK, `mode_btn` pulsed during FORCE, ring dropped → `page` = 1 throughout FORCE, then back to the pre-alarm base page. The peek is not resumed.
- `src0` = {127,100,99} selected → `data` = {99,99,99}. `peek_page` = 3 sent with a simultaneous `mode_btn` → no peek and the base advances.
- `rst` asserted mid-PEEK → all outputs are 0 asynchronously. After release, `page` = 0.
